// File: rtl/cpu_ctrl.sv
// Multi-cycle CPU control unit: fetches from a synchronous program ROM, decodes each word and
// drives the data-path selects and write enables, and resolves jumps on the registered Z flag.
module cpu_ctrl #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned IWIDTH         = 5,
  parameter int unsigned PC_WIDTH       = 8,
  parameter int unsigned REG_F_SEL_SIZE = 4,
  parameter int unsigned IN_B_SEL_SIZE  = 2
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        START,
  output logic [PC_WIDTH-1:0]         P_ADDR,
  input  logic [IWIDTH+2+WIDTH-1:0]   P_DATA,
  input  logic                        Z,
  output logic [REG_F_SEL_SIZE-1:0]   REG_F_SEL,
  output logic                        EN_REG_F,
  output logic [WIDTH-1:0]            D_MEM_ADDR,
  output logic                        D_MEM_ADDR_MODE,
  output logic                        EN_D_MEM,
  output logic [IN_B_SEL_SIZE-1:0]    IN_B_SEL,
  output logic [WIDTH-1:0]            IMM,
  output logic [IWIDTH-2:0]           ALU_OUT,
  output logic                        EN_ACC,
  output logic                        BUSY,
  output logic                        HALTED
);

  localparam int unsigned IrW = IWIDTH + 2 + WIDTH;

  localparam logic [IWIDTH-1:0] OpStr  = IWIDTH'(17);
  localparam logic [IWIDTH-1:0] OpStm  = IWIDTH'(18);
  localparam logic [IWIDTH-1:0] OpJmp  = IWIDTH'(19);
  localparam logic [IWIDTH-1:0] OpJz   = IWIDTH'(20);
  localparam logic [IWIDTH-1:0] OpJnz  = IWIDTH'(21);
  localparam logic [IWIDTH-1:0] OpHalt = IWIDTH'(22);

  typedef enum logic [2:0] {StIdle, StFetch, StDecode, StMemRd, StExec, StHalt} state_e;

  state_e              r_state, w_state_nxt;
  logic [PC_WIDTH-1:0] r_pc, w_pc_nxt, w_pc_inc, w_target;
  logic [IrW-1:0]      r_ir;
  logic [IWIDTH-1:0]   w_opc;
  logic [1:0]          w_mode;
  logic [WIDTH-1:0]    w_opnd;
  logic                w_dec_mem_src;

  assign w_opc    = r_ir[IrW-1 -: IWIDTH];
  assign w_mode   = r_ir[WIDTH +: 2];
  assign w_opnd   = r_ir[WIDTH-1:0];
  assign w_pc_inc = r_pc + PC_WIDTH'(1);
  assign w_target = w_opnd[PC_WIDTH-1:0];

  // Decided on the raw ROM word: IR is only loaded at the end of DECODE.
  assign w_dec_mem_src = ~P_DATA[IrW-1] & P_DATA[WIDTH+1];

  always_ff @(posedge CLK) begin
    if (RST) r_state <= StIdle;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pc <= '0;
      r_ir <= '0;
    end else begin
      if (r_state == StDecode) r_ir <= P_DATA;
      if (r_state == StExec) r_pc <= w_pc_nxt;
      if (r_state == StHalt && START) r_pc <= '0;
    end
  end

  always_comb begin
    w_pc_nxt = w_pc_inc;
    if (w_opc == OpJmp)             w_pc_nxt = w_target;
    else if (w_opc == OpJz && Z)    w_pc_nxt = w_target;
    else if (w_opc == OpJnz && !Z)  w_pc_nxt = w_target;
    else if (w_opc == OpHalt)       w_pc_nxt = r_pc;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   if (START) w_state_nxt = StFetch;
      StFetch:  w_state_nxt = StDecode;
      StDecode: w_state_nxt = w_dec_mem_src ? StMemRd : StExec;
      StMemRd:  w_state_nxt = StExec;
      StExec:   w_state_nxt = (w_opc == OpHalt) ? StHalt : StFetch;
      StHalt:   if (START) w_state_nxt = StFetch;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    P_ADDR          = r_pc;
    REG_F_SEL       = w_opnd[REG_F_SEL_SIZE-1:0];
    D_MEM_ADDR      = w_opnd;
    IMM             = w_opnd;
    ALU_OUT         = w_opc[IWIDTH-2:0];
    D_MEM_ADDR_MODE = w_mode[0];
    IN_B_SEL        = w_mode[1] ? IN_B_SEL_SIZE'(2) : IN_B_SEL_SIZE'(w_mode[0]);
    BUSY            = (r_state == StFetch) || (r_state == StDecode) ||
                      (r_state == StMemRd) || (r_state == StExec);
    HALTED          = (r_state == StHalt);
    EN_ACC          = 1'b0;
    EN_REG_F        = 1'b0;
    EN_D_MEM        = 1'b0;
    // Reset kills any write in flight, even mid-EXEC.
    if (r_state == StExec && !RST) begin
      EN_ACC   = ~w_opc[IWIDTH-1];
      EN_REG_F = (w_opc == OpStr);
      EN_D_MEM = (w_opc == OpStm);
    end
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: a ROM model feeds the DUT and an instruction-level model
// predicts addresses, per-cycle enables, selects and the program-counter sequence.
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, z;
  logic [7:0]  p_addr;
  logic [14:0] p_data;
  logic [3:0]  reg_f_sel;
  logic        en_reg_f, d_mem_addr_mode, en_d_mem, en_acc, busy, halted;
  logic [7:0]  d_mem_addr, imm;
  logic [1:0]  in_b_sel;
  logic [3:0]  alu_out;

  logic [14:0] rom [256];
  logic [7:0]  mpc;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) p_data <= rom[p_addr];

  cpu_ctrl dut (
    .CLK(clk), .RST(rst), .START(start), .P_ADDR(p_addr), .P_DATA(p_data), .Z(z),
    .REG_F_SEL(reg_f_sel), .EN_REG_F(en_reg_f), .D_MEM_ADDR(d_mem_addr),
    .D_MEM_ADDR_MODE(d_mem_addr_mode), .EN_D_MEM(en_d_mem), .IN_B_SEL(in_b_sel), .IMM(imm),
    .ALU_OUT(alu_out), .EN_ACC(en_acc), .BUSY(busy), .HALTED(halted)
  );

  function automatic logic [14:0] mk(input int opc, input int mode, input int opnd);
    return {5'(opc), 2'(mode), 8'(opnd)};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = mk(16, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mpc = 8'h00;
  endtask

  // Called at a negedge in IDLE or HALT; returns at the negedge of the first FETCH.
  task automatic start_cpu();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mpc = 8'h00;
  endtask

  // Executes the instruction at mpc, starting at its FETCH negedge; zmode 0/1 fixes Z, 2 random.
  task automatic do_instr(input int zmode, output bit was_halt);
    logic [14:0] w;
    logic [4:0]  opc;
    logic [1:0]  mode;
    logic [7:0]  opnd;
    logic        zv, alu;
    logic [2:0]  exp_en;
    logic [1:0]  exp_sel;
    w = rom[mpc]; opc = w[14:10]; mode = w[9:8]; opnd = w[7:0];
    zv = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
    z = zv;
    alu = (opc < 5'd16);
    exp_en = {alu, opc == 5'd17, opc == 5'd18};
    exp_sel = (mode == 2'd0) ? 2'd0 : (mode == 2'd1) ? 2'd1 : 2'd2;

    n_checks++;
    if (p_addr !== mpc || busy !== 1'b1 || halted !== 1'b0 ||
        {en_acc, en_reg_f, en_d_mem} !== 3'b000) begin
      n_fail++;
      $display("FAIL fetch: p_addr=%h busy=%b halted=%b en=%b required p_addr=%h busy=1 en=000",
               p_addr, busy, halted, {en_acc, en_reg_f, en_d_mem}, mpc);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || {en_acc, en_reg_f, en_d_mem} !== 3'b000) begin
      n_fail++;
      $display("FAIL decode: busy=%b en=%b required busy=1 en=000",
               busy, {en_acc, en_reg_f, en_d_mem});
    end
    if (alu && mode[1]) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || {en_acc, en_reg_f, en_d_mem} !== 3'b000 || in_b_sel !== 2'd2 ||
          d_mem_addr_mode !== mode[0] || reg_f_sel !== opnd[3:0]) begin
        n_fail++;
        $display("FAIL memrd: en=%b sel=%0d amode=%b rsel=%h required en=000 sel=2 amode=%b rsel=%h",
                 {en_acc, en_reg_f, en_d_mem}, in_b_sel, d_mem_addr_mode, reg_f_sel,
                 mode[0], opnd[3:0]);
      end
    end
    @(negedge clk);
    n_checks++;
    if ({en_acc, en_reg_f, en_d_mem} !== exp_en || in_b_sel !== exp_sel || imm !== opnd ||
        d_mem_addr !== opnd || reg_f_sel !== opnd[3:0] || busy !== 1'b1 ||
        (alu && alu_out !== opc[3:0]) || (mode[1] && d_mem_addr_mode !== mode[0])) begin
      n_fail++;
      $display("FAIL exec op=%b: en=%b sel=%0d imm=%h dma=%h amode=%b alu=%h required en=%b sel=%0d imm=%h",
               opc, {en_acc, en_reg_f, en_d_mem}, in_b_sel, imm, d_mem_addr, d_mem_addr_mode,
               alu_out, exp_en, exp_sel, opnd);
    end

    was_halt = (opc == 5'd22);
    case (int'(opc))
      19:      mpc = opnd;
      20:      mpc = zv ? opnd : mpc + 8'd1;
      21:      mpc = !zv ? opnd : mpc + 8'd1;
      22:      mpc = mpc;
      default: mpc = mpc + 8'd1;
    endcase
    @(negedge clk);
    if (was_halt) begin
      n_checks++;
      if (halted !== 1'b1 || busy !== 1'b0 || p_addr !== mpc ||
          {en_acc, en_reg_f, en_d_mem} !== 3'b000) begin
        n_fail++;
        $display("FAIL halt: halted=%b busy=%b p_addr=%h required halted=1 busy=0 p_addr=%h",
                 halted, busy, p_addr, mpc);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; z = 1'b0;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if ({en_acc, en_reg_f, en_d_mem} !== 3'b000 || busy !== 1'b0 || halted !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: en=%b busy=%b halted=%b required 000 0 0",
                 {en_acc, en_reg_f, en_d_mem}, busy, halted);
      end
    end
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      n_checks++;
      if (p_addr !== 8'h00 || {en_acc, en_reg_f, en_d_mem} !== 3'b000 || busy !== 1'b0 ||
          halted !== 1'b0) begin
        n_fail++;
        $display("FAIL idle: p_addr=%h en=%b busy=%b halted=%b required 00 000 0 0",
                 p_addr, {en_acc, en_reg_f, en_d_mem}, busy, halted);
      end
    end
    mpc = 8'h00;
  endtask

  task automatic test_imm_alu();
    bit h;
    clear_rom();
    rom[0] = mk(1, 0, 'h2A);
    rom[1] = mk(22, 0, 0);
    start_cpu();
    do_instr(2, h);
    do_instr(2, h);
    do_reset();
  endtask

  task automatic test_mem_store();
    bit h;
    clear_rom();
    rom[0] = mk(2, 3, 'h03);
    rom[1] = mk(18, 2, 'h40);
    rom[2] = mk(17, 1, 'h05);
    rom[3] = mk(22, 0, 0);
    start_cpu();
    repeat (4) do_instr(2, h);
    do_reset();
  endtask

  task automatic test_jumps();
    bit h;
    clear_rom();
    rom[8'h00] = mk(20, 0, 'h10);
    rom[8'h10] = mk(20, 0, 'h30);
    rom[8'h11] = mk(21, 0, 'h20);
    rom[8'h20] = mk(21, 0, 'h50);
    rom[8'h21] = mk(22, 0, 0);
    start_cpu();
    do_instr(1, h);
    do_instr(0, h);
    do_instr(0, h);
    do_instr(1, h);
    do_instr(0, h);
    do_reset();
  endtask

  task automatic test_wrap_halt();
    bit h;
    clear_rom();
    rom[8'h00] = mk(19, 0, 'hFF);
    rom[8'hFF] = mk(16, 0, 0);
    start_cpu();
    do_instr(2, h);
    do_instr(2, h);
    n_checks++;
    if (p_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL wrap: p_addr=%h required 00", p_addr);
    end
    do_reset();
    rom[8'h00] = mk(22, 0, 0);
    start_cpu();
    do_instr(2, h);
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (halted !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL halt_stay: halted=%b busy=%b required 1 0", halted, busy);
      end
    end
    start_cpu();
    do_instr(2, h);
    do_reset();
  endtask

  task automatic test_random();
    bit h;
    for (int i = 0; i < 256; i++)
      rom[i] = mk(int'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 255)));
    start_cpu();
    for (int n = 0; n < 80; n++) begin
      do_instr(2, h);
      if (h) start_cpu();
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    clear_rom();
    rom[0] = mk(18, 2, 'h40);
    start_cpu();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (en_d_mem !== 1'b0 || en_acc !== 1'b0 || en_reg_f !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_exec: en=%b required 000", {en_acc, en_reg_f, en_d_mem});
    end
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || halted !== 1'b0 || p_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_after: busy=%b halted=%b p_addr=%h required 0 0 00",
               busy, halted, p_addr);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || en_d_mem !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_idle: busy=%b en_d_mem=%b required 0 0", busy, en_d_mem);
    end
  endtask

  initial begin
    clear_rom();
    test_reset();
    test_imm_alu();
    test_mem_store();
    test_jumps();
    test_wrap_halt();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
